// File: rtl/pbd_chain_sweeper_pkg.sv
// Shared definitions for the rope chain sweeper: fixed-point widths,
// {x,y} position packing helpers and FSM state encodings.
package pbd_chain_sweeper_pkg;

  localparam int FX_W  = 32;  // 16.16 fixed-point coordinate
  localparam int POS_W = 64;  // {x, y}

  // FSM encodings kept as plain constants so older netlists keep matching
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_UP  = 3'd1;
  localparam logic [2:0] S_RD_CUR = 3'd2;
  localparam logic [2:0] S_RD_DN  = 3'd3;
  localparam logic [2:0] S_ISSUE  = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_WB     = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  function automatic logic [POS_W-1:0] pos_pack(input logic [FX_W-1:0] x,
                                                input logic [FX_W-1:0] y);
    return {x, y};
  endfunction

  function automatic logic [FX_W-1:0] pos_x(input logic [POS_W-1:0] p);
    return p[POS_W-1:FX_W];
  endfunction

  function automatic logic [FX_W-1:0] pos_y(input logic [POS_W-1:0] p);
    return p[FX_W-1:0];
  endfunction

endpackage

// File: rtl/pbd_chain_sweeper.sv
// Gauss-Seidel sweeper for the rope constraint unit. Walks nodes
// 1..NODES-1, presents (up, cur, down) to the constraint unit and writes
// the corrected cur back. Node 0 is the pinned anchor and is only read.
// After a write-back the window slides in place: the fresh result becomes
// UP and the old DOWN becomes CUR, so each node after the first costs one
// RAM read.
module pbd_chain_sweeper
  import pbd_chain_sweeper_pkg::*;
#(
  parameter int NODES = 16,
  parameter int ITERS = 4,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [POS_W-1:0] rd_data,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [POS_W-1:0] wr_data,
  output logic             ec_valid,
  output logic [FX_W-1:0]  ec_up_x,
  output logic [FX_W-1:0]  ec_up_y,
  output logic [FX_W-1:0]  ec_x,
  output logic [FX_W-1:0]  ec_y,
  output logic [FX_W-1:0]  ec_down_x,
  output logic [FX_W-1:0]  ec_down_y,
  output logic             ec_is_last,
  input  logic             ec_res_valid,
  input  logic [FX_W-1:0]  ec_res_x,
  input  logic [FX_W-1:0]  ec_res_y
);

  localparam int SW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [AW-1:0] LAST_NODE  = AW'(NODES - 1);
  localparam logic [SW-1:0] LAST_SWEEP = SW'(ITERS - 1);

  logic [2:0]       state;
  logic [AW-1:0]    node;
  logic [SW-1:0]    sweep;
  logic [POS_W-1:0] up_q, cur_q, dn_q, res_q;
  logic             fresh_q;   // RD_DN entered from RD_CUR: rd_data holds CUR
  logic             dn_rd_q;   // a DOWN read was issued in RD_DN
  logic             ec_valid_q;
  logic             last_q;
  logic             is_last;

  assign is_last = (node == LAST_NODE);

  // FSM, node/sweep counters and the UP/CUR/DOWN window
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      node       <= '0;
      sweep      <= '0;
      up_q       <= '0;
      cur_q      <= '0;
      dn_q       <= '0;
      res_q      <= '0;
      fresh_q    <= 1'b0;
      dn_rd_q    <= 1'b0;
      ec_valid_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      ec_valid_q <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          node  <= AW'(1);
          sweep <= '0;
          state <= S_RD_UP;
        end
        S_RD_UP: state <= S_RD_CUR;
        S_RD_CUR: begin
          up_q    <= rd_data;
          fresh_q <= 1'b1;
          state   <= S_RD_DN;
        end
        S_RD_DN: begin
          if (fresh_q) cur_q <= rd_data;
          fresh_q <= 1'b0;
          dn_rd_q <= !is_last;
          state   <= S_ISSUE;
        end
        S_ISSUE: begin
          // the last node has no lower neighbour; mirror CUR into DOWN
          dn_q       <= dn_rd_q ? rd_data : cur_q;
          last_q     <= is_last;
          ec_valid_q <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: if (ec_res_valid) begin
          res_q <= pos_pack(ec_res_x, ec_res_y);
          state <= S_WB;
        end
        S_WB: begin
          up_q  <= res_q;
          cur_q <= dn_q;
          if (!is_last) begin
            node  <= node + AW'(1);
            state <= S_RD_DN;
          end else if (sweep != LAST_SWEEP) begin
            sweep <= sweep + SW'(1);
            node  <= AW'(1);
            state <= S_RD_UP;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM read strobes decoded from state; write-back reuses the latched result
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state)
      S_RD_UP: begin
        rd_en   = 1'b1;
        rd_addr = node - AW'(1);
      end
      S_RD_CUR: begin
        rd_en   = 1'b1;
        rd_addr = node;
      end
      S_RD_DN: if (!is_last) begin
        rd_en   = 1'b1;
        rd_addr = node + AW'(1);
      end
      default: ;
    endcase
  end

  assign wr_en   = (state == S_WB);
  assign wr_addr = (state == S_WB) ? node : '0;
  assign wr_data = res_q;

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  assign ec_valid   = ec_valid_q;
  assign ec_is_last = last_q;
  assign ec_up_x    = pos_x(up_q);
  assign ec_up_y    = pos_y(up_q);
  assign ec_x       = pos_x(cur_q);
  assign ec_y       = pos_y(cur_q);
  assign ec_down_x  = pos_x(dn_q);
  assign ec_down_y  = pos_y(dn_q);

endmodule

// File: tb/tb_pbd_chain_sweeper.sv
// Self-checking bench for pbd_chain_sweeper. Several NODES/ITERS configs
// run side by side; each has a RAM model, a constraint-unit stub
// (result = cur + {1,1}), a scoreboard fed by a plain Gauss-Seidel model
// and a monitor that pops expectations whenever the DUT acts.
module tb_pbd_chain_sweeper;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [63:0] up;
    logic [63:0] cur;
    logic [63:0] dn;
    logic        last;
  } trip_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [63:0] d;
  } wr_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int N  = (g == 2) ? 2 : (g == 3) ? 5 : 3;
    localparam int IT = (g == 1) ? 2 : (g == 3) ? 3 : 1;
    localparam int AW = 3;

    logic          rst, start, busy, done, rd_en, wr_en, ec_valid, ec_is_last;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [63:0]   rd_data, wr_data;
    logic [31:0]   ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y;
    logic          ec_res_valid;
    logic [31:0]   ec_res_x, ec_res_y;

    logic [63:0] mem    [N];
    logic [63:0] init_m [N];
    logic [63:0] mm     [N];   // model view of RAM contents
    logic        ld;
    int          lat;
    bit          spur_en;
    bit          fin;
    int          done_exp;
    int          done_cnt;

    trip_t trip_q[$];
    wr_t   wr_q[$];
    int    rd_q[$];

    pbd_chain_sweeper #(.NODES(N), .ITERS(IT), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .ec_valid(ec_valid), .ec_up_x(ec_up_x), .ec_up_y(ec_up_y),
      .ec_x(ec_x), .ec_y(ec_y), .ec_down_x(ec_down_x), .ec_down_y(ec_down_y),
      .ec_is_last(ec_is_last), .ec_res_valid(ec_res_valid),
      .ec_res_x(ec_res_x), .ec_res_y(ec_res_y)
    );

    // position RAM: registered read, one-cycle latency
    always @(posedge clk) begin
      if (ld) begin
        for (int k = 0; k < N; k++) mem[k] <= init_m[k];
      end else begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
      end
    end

    // constraint-unit stub with programmable latency and spurious pulses
    initial begin
      trip_t held;
      bit    waiting;
      int    cnt;
      waiting = 0; cnt = 0; held = '0;
      ec_res_valid = 1'b0; ec_res_x = '0; ec_res_y = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          waiting = 0;
          ec_res_valid = 1'b0;
        end else if (waiting || ec_valid) begin
          if (waiting) begin
            chk(ec_valid === 1'b0 && {ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x,
                ec_down_y, ec_is_last} === held,
                $sformatf("c%0d wait_stable", g),
                {ec_valid, ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y},
                {1'b0, held[192:1]});
          end else begin
            held = {ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y, ec_is_last};
            cnt = lat;
            waiting = 1;
          end
          if (cnt == 0) begin
            ec_res_valid = 1'b1;
            ec_res_x = held.cur[63:32] + 32'd1;
            ec_res_y = held.cur[31:0] + 32'd1;
            waiting = 0;
          end else begin
            cnt--;
            ec_res_valid = 1'b0;
          end
        end else begin
          ec_res_valid = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
          ec_res_x = $urandom;
          ec_res_y = $urandom;
        end
      end
    end

    // monitor: pop scoreboard entries whenever the DUT acts
    initial begin
      trip_t t;
      wr_t   w;
      int    a;
      bit    prev_wr;
      prev_wr = 0;
      done_cnt = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          prev_wr = 0;
        end else begin
          if (ec_valid) begin
            t = {ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y, ec_is_last};
            if (trip_q.size() == 0) chk(0, $sformatf("c%0d ec_unexpected", g), t, 0);
            else begin
              trip_t e;
              e = trip_q.pop_front();
              chk(t === e, $sformatf("c%0d triplet", g), t, e);
            end
          end
          if (rd_en) begin
            if (rd_q.size() == 0) chk(0, $sformatf("c%0d rd_unexpected", g), rd_addr, 0);
            else begin
              a = rd_q.pop_front();
              chk(rd_addr === AW'(a), $sformatf("c%0d rd_addr", g), rd_addr, a);
            end
          end
          if (wr_en) begin
            w = {8'(wr_addr), wr_data};
            if (wr_q.size() == 0) chk(0, $sformatf("c%0d wr_unexpected", g), w, 0);
            else begin
              wr_t e;
              e = wr_q.pop_front();
              chk(w === e, $sformatf("c%0d write", g), w, e);
            end
          end
          if (done) begin
            done_cnt++;
            chk(prev_wr, $sformatf("c%0d done_after_wb", g), prev_wr, 1);
          end
          prev_wr = wr_en;
        end
      end
    end

    // reference: plain Gauss-Seidel over the model RAM, result = cur + {1,1}
    task automatic push_run();
      logic [63:0] res, dn;
      for (int s = 0; s < IT; s++) begin
        for (int a = 0; a < N; a++) rd_q.push_back(a);
        for (int n = 1; n < N; n++) begin
          dn = (n < N - 1) ? mm[n+1] : mm[n];
          trip_q.push_back({mm[n-1], mm[n], dn, 1'(n == N - 1)});
          res = {mm[n][63:32] + 32'd1, mm[n][31:0] + 32'd1};
          wr_q.push_back({8'(n), res});
          mm[n] = res;
        end
      end
      done_exp++;
    endtask

    task automatic load(input bit spec);
      for (int k = 0; k < N; k++) begin
        if (spec && k == 0)      init_m[k] = 64'h000c9b36_000aae67;
        else if (spec && k == 1) init_m[k] = 64'h000c9b36_000b4e67;
        else if (spec && k == 2) init_m[k] = 64'h000c9b36_000c3e67;
        else                     init_m[k] = {$urandom, $urandom};
        mm[k] = init_m[k];
      end
      ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
    endtask

    task automatic wait_done(input bit start_in_done);
      int n = 0;
      while (done !== 1'b1 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk(done === 1'b1, $sformatf("c%0d done_timeout", g), n, 0);
      if (start_in_done) start = 1'b1;
      @(negedge clk);
      if (start_in_done) start = 1'b0;
      chk(busy === 1'b0 && done === 1'b0, $sformatf("c%0d idle_after_done", g),
          {busy, done}, 0);
    endtask

    task automatic end_checks();
      chk(trip_q.size() == 0 && wr_q.size() == 0 && rd_q.size() == 0,
          $sformatf("c%0d drained", g), {trip_q.size(), wr_q.size(), rd_q.size()}, 0);
      for (int k = 0; k < N; k++)
        chk(mem[k] === mm[k], $sformatf("c%0d ram[%0d]", g, k), mem[k], mm[k]);
    endtask

    task automatic run_one();
      push_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk(busy === 1'b1, $sformatf("c%0d busy_after_start", g), busy, 1);
      wait_done(0);
      end_checks();
    endtask

    // stimulus
    initial begin
      logic [63:0] save [N];
      int n;
      rst = 1'b1; start = 1'b0; ld = 1'b0; lat = 1; spur_en = 0; fin = 0;
      done_exp = 0;
      for (int k = 0; k < N; k++) init_m[k] = '0;
      repeat (3) @(negedge clk);
      chk({busy, done, rd_en, wr_en, ec_valid, ec_is_last, rd_addr, wr_addr} === '0,
          $sformatf("c%0d reset_ctl", g),
          {busy, done, rd_en, wr_en, ec_valid, ec_is_last, rd_addr, wr_addr}, 0);
      chk({wr_data, ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y} === '0,
          $sformatf("c%0d reset_data", g),
          {wr_data, ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y}, 0);
      rst = 1'b0;

      // known rope, one-cycle stub
      load(N == 3);
      run_one();

      // slow stub, spurious result pulses outside WAIT
      lat = 5; spur_en = 1;
      load(0);
      run_one();

      // start held through a run: exactly one restart after IDLE
      lat = $urandom_range(0, 5);
      push_run();
      push_run();
      start = 1'b1;
      wait_done(0);
      @(negedge clk);
      start = 1'b0;
      wait_done(0);
      repeat (8) @(negedge clk);
      chk(busy === 1'b0, $sformatf("c%0d no_third_run", g), busy, 0);
      end_checks();

      // start raised only in the DONE cycle is ignored
      lat = $urandom_range(0, 3);
      push_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1);
      repeat (8) @(negedge clk);
      chk(busy === 1'b0, $sformatf("c%0d start_in_done_ignored", g), busy, 0);
      end_checks();

      // reset while waiting on the first result, then a clean full run
      lat = 5; spur_en = 0;
      for (int k = 0; k < N; k++) save[k] = mm[k];
      push_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (ec_valid !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk(ec_valid === 1'b1, $sformatf("c%0d reach_wait", g), ec_valid, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk({busy, done, wr_en, rd_en, ec_valid} === '0, $sformatf("c%0d abort_reset", g),
          {busy, done, wr_en, rd_en, ec_valid}, 0);
      @(negedge clk);
      rst = 1'b0;
      trip_q.delete(); wr_q.delete(); rd_q.delete();
      for (int k = 0; k < N; k++) mm[k] = save[k];
      done_exp--;
      spur_en = 1;
      run_one();

      chk(done_cnt == done_exp, $sformatf("c%0d done_count", g), done_cnt, done_exp);
      fin = 1;
    end
  end

  initial begin
    wait (cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
